// File: rtl/cpu_dmem_if.sv
// CPU load/store port bundle: request side driven by the core, response side by the responder.
interface cpu_dmem_if #(
  parameter int unsigned DATA_W = 32
);
  logic                MemRead;
  logic                MemWrite;
  logic [31:0]         addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] byte_en;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  logic                busy;
  logic                err;
  logic [15:0]         access_cnt;

  modport master (
    output MemRead, MemWrite, addr, wdata, byte_en,
    input  rdata, ready, busy, err, access_cnt
  );

  modport slave (
    input  MemRead, MemWrite, addr, wdata, byte_en,
    output rdata, ready, busy, err, access_cnt
  );
endinterface

// File: rtl/cpu_dmem_responder.sv
// Data-memory responder with programmable wait states and a one-cycle ready pulse.
// Optional misaligned-access checker enabled by defining DMEM_MISALIGN_CHK_EN.
module cpu_dmem_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input logic       clk,
  input logic       reset,
  cpu_dmem_if.slave bus
);
  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned NumBytes = DATA_W / 8;
  localparam logic [3:0]  WaitInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [3:0]           r_wait_cnt;
  logic [IdxW-1:0]      r_idx;
  logic [DATA_W-1:0]    r_wdata;
  logic [NumBytes-1:0]  r_be;
  logic                 r_write;
  logic                 r_mis;
  logic [15:0]          r_access_cnt;
  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic                 w_req;
  logic                 w_misaligned;
  logic                 w_unused;
  logic [DATA_W-1:0]    w_old;
  logic [DATA_W-1:0]    w_merged;

  assign w_req = bus.MemRead | bus.MemWrite;

`ifdef DMEM_MISALIGN_CHK_EN
  assign w_misaligned = (bus.addr[1:0] != 2'b00);
  assign w_unused     = ^bus.addr[31:IdxW+2];
`else
  assign w_misaligned = 1'b0;
  assign w_unused     = ^{bus.addr[31:IdxW+2], bus.addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_req) w_state_next = (LATENCY > 0) ? StWait : StResp;
      StWait:  if (r_wait_cnt == 4'd0) w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Request fields are frozen at accept so later input changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait_cnt   <= 4'd0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_write      <= 1'b0;
      r_mis        <= 1'b0;
      r_access_cnt <= 16'd0;
    end else begin
      if (r_state == StIdle && w_req) begin
        r_wait_cnt <= WaitInit;
        r_idx      <= bus.addr[2 +: IdxW];
        r_wdata    <= bus.wdata;
        r_be       <= bus.byte_en;
        r_write    <= bus.MemWrite;
        r_mis      <= w_misaligned;
      end else if (r_state == StWait && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (r_state == StResp) r_access_cnt <= r_access_cnt + 16'd1;
    end
  end

  assign w_old = r_mem[r_idx];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NumBytes; i++) begin
      if (r_be[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  // Array is not reset; a reset at the RESP-ending edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (reset && r_state == StResp && r_write && !r_mis) r_mem[r_idx] <= w_merged;
  end

  always_comb begin
    bus.busy       = (r_state != StIdle);
    bus.ready      = (r_state == StResp);
    bus.access_cnt = r_access_cnt;
    bus.rdata      = '0;
    if (bus.ready && !r_write && !r_mis) bus.rdata = w_old;
`ifdef DMEM_MISALIGN_CHK_EN
    bus.err = bus.ready & r_mis;
`else
    bus.err = 1'b0;
`endif
  end
endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Self-checking bench for cpu_dmem_responder: transaction-level model plus directed checks.
module tb_cpu_dmem_responder;
  localparam int unsigned L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_dmem_if #(.DATA_W(32)) bus ();

  cpu_dmem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(L)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: an access occupies cycles 1..L+1 after its accept edge; ready in the last one.
  logic [31:0] m_mem   [256];
  bit          m_valid [256];
  int          m_t   = 0;
  int          m_cnt = 0;
  int          m_idx = 0;
  bit          m_wr  = 1'b0;
  bit          m_mis = 1'b0;
  logic [31:0] m_wd;
  logic [3:0]  m_be;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t   = 0;
      m_cnt = 0;
    end else if (m_t == L + 1) begin
      if (m_wr && !m_mis) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) m_mem[m_idx][8*b +: 8] = m_wd[8*b +: 8];
        m_valid[m_idx] = m_valid[m_idx] || (m_be == 4'hF);
      end
      m_cnt = (m_cnt + 1) % 65536;
      m_t   = 0;
    end else if (m_t > 0) begin
      m_t++;
    end else if (bus.MemRead || bus.MemWrite) begin
      m_wr  = bus.MemWrite;
      m_idx = int'(bus.addr[9:2]);
      m_wd  = bus.wdata;
      m_be  = bus.byte_en;
`ifdef DMEM_MISALIGN_CHK_EN
      m_mis = (bus.addr[1:0] != 2'b00);
`else
      m_mis = 1'b0;
`endif
      m_t   = 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, m_t > 0});
      chk("ready", {31'd0, bus.ready}, {31'd0, m_t == L + 1});
      chk("err", {31'd0, bus.err}, {31'd0, (m_t == L + 1) && m_mis});
      chk("access_cnt", {16'd0, bus.access_cnt}, m_cnt);
      if (m_t != L + 1) chk("rdata_idle", bus.rdata, 32'd0);
      else if (m_mis) chk("rdata_mis", bus.rdata, 32'd0);
      else if (!m_wr && m_valid[m_idx]) chk("rdata_rd", bus.rdata, m_mem[m_idx]);
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] d, output int n, output int nb,
                        output logic e);
    @(negedge clk);
    bus.MemRead = rd; bus.MemWrite = wr; bus.addr = a; bus.wdata = wd; bus.byte_en = be;
    @(posedge clk);
    #1;
    n = 1;
    nb = bus.busy ? 1 : 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.busy) nb++;
    end
    d = bus.rdata;
    e = bus.err;
    @(negedge clk);
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
  endtask

  logic [31:0] d;
  logic        e;
  int          n, nb;

  initial begin
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.addr = '0; bus.wdata = '0; bus.byte_en = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_cnt", {16'd0, bus.access_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, n, nb, e);
    chk("t1_latency", n, 32'd3);
    chk("t1_busy_cycles", nb, 32'd3);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, d, n, nb, e);
    chk("t1_rdata", d, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    chk("t1_cnt", {16'd0, bus.access_cnt}, 32'd2);

    access(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, d, n, nb, e);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, d, n, nb, e);
    chk("merge_rdata", d, 32'hDEADBEAA);

    access(1'b0, 1'b1, 32'h400, 32'h11, 4'hF, d, n, nb, e);
    access(1'b1, 1'b0, 32'h000, 32'h0, 4'h0, d, n, nb, e);
    chk("wrap_rdata", d, 32'h00000011);

    access(1'b1, 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, d, n, nb, e);
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, d, n, nb, e);
    chk("both_rdata", d, 32'h5A5A5A5A);

    access(1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, d, n, nb, e);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("mis_err", {31'd0, e}, 32'd1);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, d, n, nb, e);
    chk("mis_word", d, 32'hDEADBEAA);
`else
    chk("mis_err", {31'd0, e}, 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, d, n, nb, e);
    chk("mis_word", d, 32'hFFFFFFFF);
`endif

    // Held request: two reads back to back, one ready every L+2 cycles.
    @(negedge clk);
    bus.MemRead = 1'b1; bus.addr = 32'h20;
    n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.ready !== 1'b1 && n < 40);
    chk("b2b_period", n, L + 2);
    chk("b2b_rdata", bus.rdata, 32'h5A5A5A5A);
    @(negedge clk);
    bus.MemRead = 1'b0;

    access(1'b0, 1'b1, 32'h30, 32'h0, 4'hF, d, n, nb, e);
    @(negedge clk);
    bus.MemWrite = 1'b1; bus.addr = 32'h30; bus.wdata = 32'h12345678; bus.byte_en = 4'hF;
    n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("rst_mid_reach_resp", {31'd0, bus.ready}, 32'd1);
    @(negedge clk);
    bus.MemWrite = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_cnt", {16'd0, bus.access_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, d, n, nb, e);
    chk("rst_mid_rdata", d, 32'h0);

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_dmem_responder.md
# cpu_dmem_responder

Data-memory responder for the CPU's load/store port. It accepts the CPU-driven MemRead/MemWrite requests, inserts a programmable number of wait states, and performs the access on an internal word array. It completes every access with a one-cycle ready pulse. It sits between the CPU core and its data memory, replacing a zero-latency memory model so the core's stall path is exercised.

## Interface
- DATA_W, 32: data width; byte enables are DATA_W/8 wide.
- DEPTH, 256: number of words in the array; power of two.
- LATENCY, 2: wait-state cycles between accept and response; legal range 0..15.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- MemRead  in  1  read request; held high by CPU until ready.
- MemWrite  in  1  write request; held high by CPU until ready.
- addr  in  32  byte address.
- wdata  in  DATA_W  store data.
- byte_en  in  DATA_W/8  per-byte write mask; ignored for reads.
- rdata  out  DATA_W  load data; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while an access is in flight (state != IDLE).
- err  out  1  access error; valid with ready. Tied 0 when the checker is compiled out.
- access_cnt  out  16  count of completed accesses.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: MemRead|MemWrite high at a clock edge accepts the request.
  - addr, wdata, byte_en and type are captured; input changes after capture are ignored.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
- WAIT: down-counter loaded with LATENCY-1 and decremented each cycle. Moves to RESP when the counter reaches 0.
- RESP: ready=1, busy=1. Returns to IDLE unconditionally.
  - Read: rdata = array[word index].
  - Write: merged word is committed at the edge ending RESP, with byte i taken from wdata when byte_en[i]=1.
- MemRead and MemWrite both high at accept: treated as a write; the read is dropped.
- Word index = addr[2 +: log2(DEPTH)]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- A request still high in the IDLE cycle after RESP starts a new access. The CPU must drop the request on seeing ready.
- access_cnt increments at the edge ending each RESP cycle and wraps 0xFFFF -> 0x0000.
- rdata is driven to 0 outside RESP.

## Timing
- Request sampled at edge k. busy=1 from cycle k+1. ready=1 in cycle k+1+LATENCY for exactly one cycle.
- Total latency from first sampled request to ready: LATENCY+1 cycles. Minimum 1 cycle when LATENCY=0.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- Reset values: ready 0, busy 0, err 0, rdata 0, access_cnt 0, state IDLE, wait counter 0. Array contents are not reset.
- Reset low mid-access, including at the edge ending RESP:
  - access is abandoned and the write is suppressed;
  - access_cnt is not incremented;
  - the next cycle is IDLE with all outputs at reset values.
- Read-after-write to the same word: the read accepted in the IDLE cycle following the write's RESP returns the new data.

## Configuration
- Macro DMEM_MISALIGN_CHK_EN.
- Defined:
  - an access with addr[1:0] != 2'b00 still runs the full LATENCY sequence;
  - it completes with ready=1, err=1, rdata=0;
  - writes are suppressed;
  - access_cnt still increments.
- Not defined: addr[1:0] is ignored, the access goes to the containing word, and err is constant 0.

## Test plan
- LATENCY=2: write 0xDEADBEEF, byte_en=4'hF, addr 0x10 -> busy high 3 cycles, ready in 3rd cycle after accept. Then read 0x10 -> rdata=0xDEADBEEF with ready, access_cnt=2.
- Byte merge: after the above, write 0x000000AA with byte_en=4'b0001 to 0x10, then read 0x10 -> rdata=0xDEADBEAA.
- Wrap: DEPTH=256, write 0x11 to addr 0x400, then read addr 0x000 -> rdata=0x00000011.
- Simultaneous requests: MemRead=MemWrite=1 with wdata 0x5A5A5A5A at 0x20 -> a subsequent read of 0x20 returns 0x5A5A5A5A.
- Reset mid-op: start write of 0x12345678 to 0x30 (prior value 0), pull reset low at the edge ending RESP -> no write, ready=0 next cycle, busy=0, access_cnt=0, and a later read of 0x30 returns 0.
- DMEM_MISALIGN_CHK_EN: write 0xFFFFFFFF to addr 0x12 -> ready=1 with err=1, and word 0x10 is unchanged. Without the macro, the same write lands in word 0x10 and err stays 0.
